// File: rtl/daub6_pkg.sv
// Shared defaults and state type for the Daub-6 tap window
// and the combinational filter stages that consume it.
package daub6_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_TAPS   = 9;
  localparam int DEF_DECIM      = 2;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int phase_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/daub6_delay_line.sv
// History shift register; the window view appends the incoming
// sample so the post-shift window is visible before the edge.
module daub6_delay_line
  import daub6_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_NUM_TAPS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [DEPTH*WIDTH-1:0]   window
);

  logic [(DEPTH-1)*WIDTH-1:0] hist;

  assign window = {din, hist};

  // Only the newest DEPTH-1 samples are kept; the oldest drops out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (clear) begin
      hist <= '0;
    end else if (load) begin
      hist <= window[DEPTH*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/daub6_tap_window.sv
// Sliding, decimating sample window feeding the Daub-6 stage,
// with frame-aware refill and a one-deep valid/ready output.
module daub6_tap_window
  import daub6_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int DECIM      = DEF_DECIM
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] m_taps,
  output logic                           m_last
);

  localparam int CW = cnt_width(NUM_TAPS);
  localparam int PW = phase_width(DECIM);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_TAPS);
  localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);

  state_t                         state;
  state_t                         state_next;
  logic [CW-1:0]                  count;
  logic [CW-1:0]                  count_next;
  logic [PW-1:0]                  phase;
  logic [PW-1:0]                  phase_next;
  logic                           accept;
  logic                           emit;
  logic                           clear;
  logic [NUM_TAPS*DATA_WIDTH-1:0] window;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  daub6_delay_line #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (NUM_TAPS)
  ) u_line (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .clear  (clear),
    .din    (s_data),
    .window (window)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      count <= '0;
      phase <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      phase <= phase_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    phase_next = phase;
    emit       = 1'b0;
    clear      = 1'b0;
    if (accept) begin
      unique case (state)
        FILL: begin
          if (count == CNT_LAST) begin
            emit       = 1'b1;
            state_next = STREAM;
            count_next = CNT_FULL;
            phase_next = '0;
          end else begin
            count_next = count + CW'(1);
          end
        end
        STREAM: begin
          if (phase == PH_LAST) begin
            emit       = 1'b1;
            phase_next = '0;
          end else begin
            phase_next = phase + PW'(1);
          end
        end
      endcase
      // End of frame: window above is still captured, then refill.
      if (s_last) begin
        clear      = 1'b1;
        state_next = FILL;
        count_next = '0;
        phase_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_taps  <= '0;
    end else if (emit) begin
      m_valid <= 1'b1;
      m_last  <= s_last;
      m_taps  <= window;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_daub6_tap_window.sv
// Directed and random stimulus for daub6_tap_window against
// a queue-based model of the sliding decimating window.
module tb_daub6_tap_window;
  import daub6_pkg::*;

  localparam int W   = DEF_DATA_WIDTH;
  localparam int NT  = DEF_NUM_TAPS;
  localparam int DEC = DEF_DECIM;
  localparam int TW  = NT * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [TW-1:0] m_taps;
  logic          m_last;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  frame[$];
  int            n = 0;
  logic          exp_valid = 1'b0;
  logic          exp_last = 1'b0;
  logic [TW-1:0] exp_taps = '0;

  daub6_tap_window #(
    .DATA_WIDTH (W),
    .NUM_TAPS   (NT),
    .DECIM      (DEC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_taps  (m_taps),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [TW-1:0] got,
                     input logic [TW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] seq(input int start);
    logic [TW-1:0] r;
    r = '0;
    for (int k = 0; k < NT; k++) r[k*W +: W] = W'(start + k);
    return r;
  endfunction

  task automatic model_edge(input logic acc, input logic [W-1:0] d,
                            input logic l, input logic r);
    bit emit;
    emit = 1'b0;
    if (acc) begin
      frame.push_back(d);
      if (frame.size() > NT) void'(frame.pop_front());
      n++;
      emit = (n == NT) || (n > NT && (n - NT) % DEC == 0);
    end
    if (emit) begin
      exp_valid = 1'b1;
      exp_last  = l;
      for (int k = 0; k < NT; k++) exp_taps[k*W +: W] = frame[k];
    end else if (r) begin
      exp_valid = 1'b0;
    end
    if (acc && l) begin
      frame.delete();
      n = 0;
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic l, input logic r);
    logic acc;
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = r;
    #1;
    chk("s_ready", TW'(s_ready), TW'(!exp_valid || r));
    acc = v && (!exp_valid || r);
    @(posedge clk);
    model_edge(acc, d, l, r);
    #1;
    chk("m_valid", TW'(m_valid), TW'(exp_valid));
    if (exp_valid) begin
      chk("m_taps", m_taps, exp_taps);
      chk("m_last", TW'(m_last), TW'(exp_last));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("rst_m_valid", TW'(m_valid), '0);
    chk("rst_s_ready", TW'(s_ready), TW'(1));
    chk("rst_m_last", TW'(m_last), '0);
    chk("rst_m_taps", m_taps, '0);
    frame.delete();
    n = 0;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Fill, then decimated streaming.
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b1, W'(i), 1'b0, 1'b1);
    chk("win_1_9", m_taps, seq(1));
    chk("win_1_9_last", TW'(m_last), '0);
    step(1'b1, W'(10), 1'b0, 1'b1);
    chk("no_win_10", TW'(m_valid), '0);
    step(1'b1, W'(11), 1'b0, 1'b1);
    chk("win_3_11", m_taps, seq(3));

    // Backpressure: window held, queued sample taken on release.
    repeat (5) begin
      step(1'b1, W'(12), 1'b0, 1'b0);
      chk("hold_taps", m_taps, seq(3));
    end
    step(1'b1, W'(12), 1'b0, 1'b1);
    chk("consumed", TW'(m_valid), '0);
    step(1'b1, W'(13), 1'b0, 1'b1);
    chk("win_5_13", m_taps, seq(5));

    // Frame end then fresh frame.
    do_reset();
    for (int i = 1; i <= 11; i++) step(1'b1, W'(i), i == 11, 1'b1);
    chk("last_win", m_taps, seq(3));
    chk("last_flag", TW'(m_last), TW'(1));
    for (int i = 100; i <= 108; i++) step(1'b1, W'(i), 1'b0, 1'b1);
    chk("new_frame_win", m_taps, seq(100));
    chk("new_frame_last", TW'(m_last), '0);

    // Short frame yields nothing.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, W'(i), i == 5, 1'b1);
      chk("short_no_win", TW'(m_valid), '0);
    end
    for (int i = 200; i <= 208; i++) step(1'b1, W'(i), 1'b0, 1'b1);
    chk("after_short", m_taps, seq(200));

    // Reset mid-frame and with a pending window.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b0, 1'b1);
    do_reset();
    for (int i = 50; i <= 57; i++) step(1'b1, W'(i), 1'b0, 1'b1);
    chk("rst_refill_8", TW'(m_valid), '0);
    step(1'b1, W'(58), 1'b0, 1'b0);
    chk("rst_refill_9", m_taps, seq(50));
    step(1'b0, '0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    chk("pending_dropped", TW'(m_valid), '0);
    for (int i = 70; i <= 78; i++) step(1'b1, W'(i), 1'b0, 1'b1);
    chk("post_rst_win", m_taps, seq(70));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom),
           $urandom_range(0, 24) == 0, $urandom_range(0, 4) < 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/daub6_tap_window.md
DAUB6_TAP_WINDOW -- requirements
Module: daub6_tap_window

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of each signed sample.
REQ-002 SHALL have parameter NUM_TAPS, default 9, number of window taps presented downstream.
REQ-003 SHALL have parameter DECIM, default 2, number of accepted samples between successive windows in steady state.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port s_valid  input  1  upstream sample valid.
REQ-007 SHALL have port s_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have port s_data  input  DATA_WIDTH  signed sample.
REQ-009 SHALL have port s_last  input  1  sample is the final one of its frame.
REQ-010 SHALL have port m_valid  output  1  window valid toward the Daub-6 combinational stage.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the window.
REQ-012 SHALL have port m_taps  output  NUM_TAPS*DATA_WIDTH  window; tap k at bits [k*DATA_WIDTH +: DATA_WIDTH], tap 0 oldest, tap NUM_TAPS-1 newest; maps tap k to combinational input in<k>.
REQ-013 SHALL have port m_last  output  1  window is the last of its frame.

Function
REQ-014 A sample is accepted when s_valid and s_ready are both 1 on a rising edge; the window register then shifts one place toward tap 0 and loads s_data into tap NUM_TAPS-1.
REQ-015 s_ready SHALL equal (not m_valid) or m_ready, combinationally; a pending window is never overwritten.
REQ-016 A fill counter SHALL count accepted samples in the current frame, saturating at NUM_TAPS; a phase counter (mod DECIM) SHALL advance on each accept once saturated.
REQ-017 FSM states: FILL (counter < NUM_TAPS) and STREAM (counter = NUM_TAPS); FILL->STREAM on the accept that makes the count NUM_TAPS; STREAM->FILL on an accept with s_last=1; any state->FILL on reset.
REQ-018 A window SHALL be emitted on the accept that brings the count to NUM_TAPS, and thereafter on every DECIM-th accept (samples 9, 11, 13, ... for defaults).
REQ-019 m_valid SHALL assert on the clock edge that performs the emitting accept (registered, one-cycle latency from the accept), with m_taps holding the post-shift window.
REQ-020 m_valid SHALL deassert on an edge with m_ready=1 unless the same edge performs a new emitting accept, in which case m_valid stays 1 and m_taps update.
REQ-021 While m_valid=1 and m_ready=0, m_taps, m_last and m_valid SHALL hold stable.
REQ-022 m_last SHALL be 1 with a window emitted by an accept carrying s_last=1, else 0.
REQ-023 An accept with s_last=1 SHALL clear the fill and phase counters and all taps to 0 after the window (if any) is captured; a frame ending before NUM_TAPS samples produces no window and no m_last.
REQ-024 Arithmetic: no arithmetic on sample data; counters SHALL be wide enough for NUM_TAPS without wrap.

Reset
REQ-025 While rst=1: m_valid=0, m_last=0, m_taps=0, counters=0, state=FILL, hence s_ready=1.
REQ-026 Reset asserted mid-frame or with a pending window SHALL discard all state immediately; the pending window is never delivered.

Structure
REQ-027 Package daub6_pkg SHALL hold DATA_WIDTH, NUM_TAPS and DECIM defaults and the FSM state enum, shared with the Daub-6 combinational stages.
REQ-028 A sub-module daub6_delay_line (parameterised shift register with load-enable and synchronous clear) SHALL implement the tap storage; control stays in daub6_tap_window.

Verification
REQ-029 Reset, m_ready=1, send 1..9 -> m_valid=1 one cycle after 9th accept, taps 0..8 = 1..9, m_last=0.
REQ-030 Continue 10, 11 -> no window after 10; window 3..11 after 11.
REQ-031 Window pending with m_ready=0 for 5 cycles -> s_ready=0, m_taps stable; raise m_ready -> window consumed and the queued sample accepted on that edge.
REQ-032 Send 1..11 with s_last on 11 -> window 3..11 with m_last=1; then 100..108 -> first window 100..108, m_last=0.
REQ-033 s_last on 5th sample -> no window; next 9 samples yield one window of exactly those samples.
REQ-034 Assert rst after 5 samples and also with a window pending -> m_valid=0 at once, s_ready=1, 9 new samples required before the next window.
